gpio_bank: RTL and testbench

- Parametrised memory-mapped GPIO bank; successor to the single-register IO decode block on the core's data-memory path.
- Adds a configurable pin width and base address, a metastability synchroniser, and atomic set/clear/toggle of outputs.
- Adds per-pin rising/falling edge interrupts with sticky write-1-to-clear status and one level irq line to the core.
- Read data mux is combinational: loads complete in the same cycle, as for data memory.

---
 rtl/gpio_bank.sv | 139 +++++++++++++
 tb/tb_gpio_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
`default_nettype none
// =============================================================================
// Module      : gpio_bank
// Description : Memory-mapped GPIO bank with atomic set/clear/toggle, input
//               synchroniser and per-pin edge interrupts (sticky W1C status).
// Revision    : 1.0 - initial release
// =============================================================================
module gpio_bank #(
    parameter int          GPIO_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_mem,
    input  logic              read_mem,
    input  logic [31:0]       data_address,
    input  logic [31:0]       data_to_write,
    input  logic [31:0]       data_from_mem,
    output logic [31:0]       data_read,
    output logic [GPIO_W-1:0] io_out,
    output logic [GPIO_W-1:0] io_oe,
    input  logic [GPIO_W-1:0] io_in,
    output logic              irq
);

    localparam logic [5:0] c_off_out    = 6'h00;
    localparam logic [5:0] c_off_oe     = 6'h04;
    localparam logic [5:0] c_off_in     = 6'h08;
    localparam logic [5:0] c_off_set    = 6'h0C;
    localparam logic [5:0] c_off_clr    = 6'h10;
    localparam logic [5:0] c_off_tgl    = 6'h14;
    localparam logic [5:0] c_off_rise   = 6'h18;
    localparam logic [5:0] c_off_fall   = 6'h1C;
    localparam logic [5:0] c_off_status = 6'h20;

    logic [GPIO_W-1:0] out_q,     out_d;
    logic [GPIO_W-1:0] oe_q,      oe_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d;
    logic [GPIO_W-1:0] fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] status_q,  status_d;
    logic [GPIO_W-1:0] prev_q,    prev_d;
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] sync_d [SYNC_STAGES];

    logic [5:0]        w_offset;
    logic              w_hit;
    logic              w_wr;
    logic [GPIO_W-1:0] w_wdata;
    logic [GPIO_W-1:0] w_sync_in;
    logic [GPIO_W-1:0] w_w1c;
    logic [GPIO_W-1:0] w_rise_evt;
    logic [GPIO_W-1:0] w_fall_evt;
    logic [31:0]       w_rd_reg;

    assign w_offset  = data_address[5:0];
    assign w_hit     = (data_address[31:6] == BASE_ADDR[31:6]) &&
                       (data_address[1:0] == 2'b00) &&
                       (w_offset <= c_off_status);
    assign w_wr      = write_mem && w_hit;
    assign w_wdata   = data_to_write[GPIO_W-1:0];
    assign w_sync_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w_w1c     = '0;
        if (w_wr) begin
            case (w_offset)
                c_off_out:    out_d     = w_wdata;
                c_off_oe:     oe_d      = w_wdata;
                c_off_set:    out_d     = out_q | w_wdata;
                c_off_clr:    out_d     = out_q & ~w_wdata;
                c_off_tgl:    out_d     = out_q ^ w_wdata;
                c_off_rise:   rise_en_d = w_wdata;
                c_off_fall:   fall_en_d = w_wdata;
                c_off_status: w_w1c     = w_wdata;
                default:      ;
            endcase
        end
    end

    // Edge events are OR-ed in after the W1C mask so a coincident event wins.
    always_comb begin
        w_rise_evt = w_sync_in & ~prev_q & rise_en_q;
        w_fall_evt = ~w_sync_in & prev_q & fall_en_q;
        status_d   = (status_q & ~w_w1c) | w_rise_evt | w_fall_evt;
        prev_d     = w_sync_in;
        sync_d[0]  = io_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
        end
    end

    // Write-only registers and unused upper bits fall through as zero.
    always_comb begin
        w_rd_reg = '0;
        case (w_offset)
            c_off_out:    w_rd_reg[GPIO_W-1:0] = out_q;
            c_off_oe:     w_rd_reg[GPIO_W-1:0] = oe_q;
            c_off_in:     w_rd_reg[GPIO_W-1:0] = w_sync_in;
            c_off_rise:   w_rd_reg[GPIO_W-1:0] = rise_en_q;
            c_off_fall:   w_rd_reg[GPIO_W-1:0] = fall_en_q;
            c_off_status: w_rd_reg[GPIO_W-1:0] = status_q;
            default:      ;
        endcase
    end

    assign data_read = (read_mem && w_hit) ? w_rd_reg : data_from_mem;
    assign io_out    = out_q;
    assign io_oe     = oe_q;
    assign irq       = |(status_q & (rise_en_q | fall_en_q));

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// =============================================================================
// Module      : tb_gpio_bank
// Description : Directed-vector self-checking bench for gpio_bank.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_gpio_bank;

    localparam logic [31:0] c_base   = 32'hFFFFFF00;
    localparam logic [31:0] c_out    = c_base + 32'h00;
    localparam logic [31:0] c_oe     = c_base + 32'h04;
    localparam logic [31:0] c_in     = c_base + 32'h08;
    localparam logic [31:0] c_set    = c_base + 32'h0C;
    localparam logic [31:0] c_clr    = c_base + 32'h10;
    localparam logic [31:0] c_tgl    = c_base + 32'h14;
    localparam logic [31:0] c_rise   = c_base + 32'h18;
    localparam logic [31:0] c_fall   = c_base + 32'h1C;
    localparam logic [31:0] c_status = c_base + 32'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_mem;
    logic        read_mem;
    logic [31:0] data_address;
    logic [31:0] data_to_write;
    logic [31:0] data_from_mem;
    logic [31:0] data_read;
    logic [31:0] io_out;
    logic [31:0] io_oe;
    logic [31:0] io_in;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    gpio_bank #(
        .GPIO_W      (32),
        .BASE_ADDR   (c_base),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_mem     (write_mem),
        .read_mem      (read_mem),
        .data_address  (data_address),
        .data_to_write (data_to_write),
        .data_from_mem (data_from_mem),
        .data_read     (data_read),
        .io_out        (io_out),
        .io_oe         (io_oe),
        .io_in         (io_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Store spans exactly one rising edge; returns at the following negedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        data_address  = a;
        data_to_write = d;
        write_mem     = 1'b1;
        @(negedge clk);
        write_mem     = 1'b0;
    endtask

    // Combinational load, never crosses a clock edge.
    task automatic check_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        data_address = a;
        read_mem     = 1'b1;
        #1;
        check_eq(tag, data_read, exp);
        read_mem     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        write_mem     = 1'b0;
        read_mem      = 1'b0;
        data_address  = 32'h0;
        data_to_write = 32'h0;
        data_from_mem = 32'h12345678;
        io_in         = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and pass-through
        check_eq("rst_io_out", io_out, 32'h0);
        check_eq("rst_io_oe", io_oe, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        check_load("rst_out", c_out, 32'h0);
        check_load("rst_oe", c_oe, 32'h0);
        check_load("rst_status", c_status, 32'h0);
        check_load("miss_passthru", 32'h0000_1000, 32'h12345678);
        data_address = c_out;
        #1;
        check_eq("noread_passthru", data_read, 32'h12345678);

        // Output register and atomic ops
        store(c_out, 32'h0000_00F0);
        check_eq("out_write", io_out, 32'h0000_00F0);
        store(c_set, 32'h1);
        check_eq("out_set", io_out, 32'h0000_00F1);
        store(c_clr, 32'h10);
        check_eq("out_clr", io_out, 32'h0000_00E1);
        store(c_tgl, 32'h300);
        check_eq("out_tgl", io_out, 32'h0000_03E1);
        check_load("out_read", c_out, 32'h0000_03E1);
        check_load("wo_reads_zero", c_set, 32'h0);
        store(c_oe, 32'h0000_A5A5);
        check_eq("oe_write", io_oe, 32'h0000_A5A5);
        store(c_in, 32'hFFFF_FFFF);
        check_load("in_write_ignored", c_in, 32'h0);

        // Rising edge on pin 2 through the synchroniser
        store(c_rise, 32'h4);
        check_load("rise_en_read", c_rise, 32'h4);
        io_in = 32'h4;
        @(posedge clk); #1;
        check_load("in_edge_k", c_in, 32'h0);
        @(posedge clk); #1;
        check_load("in_edge_k1", c_in, 32'h4);
        check_load("status_edge_k1", c_status, 32'h0);
        check_eq("irq_edge_k1", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check_load("status_edge_k2", c_status, 32'h4);
        check_eq("irq_edge_k2", {31'h0, irq}, 32'h1);
        store(c_status, 32'h4);
        check_load("status_w1c", c_status, 32'h0);
        check_eq("irq_after_w1c", {31'h0, irq}, 32'h0);

        // Falling edge on pin 0 coinciding with a W1C of bit 0
        io_in = 32'h5;
        repeat (3) @(negedge clk);
        check_load("status_no_rise0", c_status, 32'h0);
        store(c_fall, 32'h1);
        io_in = 32'h4;
        @(negedge clk);
        @(negedge clk);
        data_address  = c_status;
        data_to_write = 32'h1;
        write_mem     = 1'b1;
        @(negedge clk);
        write_mem     = 1'b0;
        check_load("set_wins_w1c", c_status, 32'h1);
        check_eq("irq_set_wins", {31'h0, irq}, 32'h1);
        store(c_status, 32'h1);
        check_load("status_clr0", c_status, 32'h0);

        // Short pulse on disabled pin 5, then late enable
        @(negedge clk);
        #3 io_in = 32'h24;
        #4 io_in = 32'h04;
        repeat (4) @(negedge clk);
        check_load("pulse_disabled", c_status, 32'h0);
        store(c_rise, 32'h24);
        repeat (3) @(negedge clk);
        check_load("late_enable_no_status", c_status, 32'h0);
        io_in = 32'h24;
        repeat (4) @(negedge clk);
        check_load("new_edge_status", c_status, 32'h20);
        check_eq("new_edge_irq", {31'h0, irq}, 32'h1);
        store(c_rise, 32'h4);
        check_load("disable_keeps_status", c_status, 32'h20);
        check_eq("disable_masks_irq", {31'h0, irq}, 32'h0);
        store(c_rise, 32'h24);
        check_eq("reenable_irq", {31'h0, irq}, 32'h1);

        // Asynchronous reset mid-cycle
        store(c_out, 32'hFFFF_FFFF);
        check_eq("pre_rst_io_out", io_out, 32'hFFFF_FFFF);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
        check_eq("async_rst_io_out", io_out, 32'h0);
        check_load("async_rst_status", c_status, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Pin high through reset yields a rising event once enabled
        store(c_rise, 32'h20);
        repeat (3) @(negedge clk);
        check_load("post_rst_rise", c_status, 32'h20);

        // Misaligned and out-of-range accesses
        store(c_base + 32'h2, 32'hFF);
        check_eq("misaligned_io_out", io_out, 32'h0);
        check_load("misaligned_out", c_out, 32'h0);
        check_load("misaligned_read", c_base + 32'h2, 32'h12345678);
        store(c_base + 32'h24, 32'hFF);
        check_load("oor_read", c_base + 32'h24, 32'h12345678);
        check_load("oor_no_effect", c_out, 32'h0);

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        data_address  = c_out;
        data_to_write = 32'h55;
        write_mem     = 1'b1;
        read_mem      = 1'b1;
        #1;
        check_eq("rw_pre_value", data_read, 32'h0);
        @(negedge clk);
        write_mem = 1'b0;
        read_mem  = 1'b0;
        check_eq("rw_write_done", io_out, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
